// File: rtl/fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_pkg : shared constants and helpers for the synchronous FIFO     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package fifo_pkg;

    localparam int FIFO_WIDTH_DEF = 8;
    localparam int FIFO_DEPTH_DEF = 16;

    // Ceiling log2, evaluated at elaboration time to size pointers.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_ram : simple dual-port RAM, synchronous write and read          |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module fifo_ram #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Read and write share one process so a same-address access returns the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo_param : parametrised single-clock FIFO with status flags   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH     = FIFO_WIDTH_DEF,
    parameter int DEPTH     = FIFO_DEPTH_DEF,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH-1:0]        buf_in,
    input  logic                    wt_en,
    input  logic                    rd_en,
    input  logic                    err_clr,
    output logic [WIDTH-1:0]        buf_out,
    output logic                    buf_valid,
    output logic                    buf_empty,
    output logic                    buf_full,
    output logic                    almost_empty,
    output logic                    almost_full,
    output logic [clog2(DEPTH):0]   count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int ADDR_W = clog2(DEPTH);
    localparam logic [ADDR_W:0] c_depth = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] c_af    = (ADDR_W + 1)'(AF_THRESH);
    localparam logic [ADDR_W:0] c_ae    = (ADDR_W + 1)'(AE_THRESH);

    logic [ADDR_W-1:0] r_top;
    logic [ADDR_W-1:0] r_bottom;
    logic [ADDR_W:0]   r_count;
    logic              r_valid;
    logic              r_empty;
    logic              r_full;
    logic              r_ae;
    logic              r_af;
    logic              r_ovf;
    logic              r_unf;
    logic              r_out_zero;

    logic              w_rd_acc;
    logic              w_wr_acc;
    logic [ADDR_W:0]   w_count_nxt;
    logic [WIDTH-1:0]  w_ram_q;

    assign w_rd_acc = rd_en & ~r_empty;
    assign w_wr_acc = wt_en & (~r_full | w_rd_acc);

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_acc && !w_rd_acc) begin
            w_count_nxt = r_count + 1'b1;
        end else if (w_rd_acc && !w_wr_acc) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    fifo_ram #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (w_wr_acc),
        .wr_addr (r_top),
        .wr_data (buf_in),
        .rd_en   (w_rd_acc),
        .rd_addr (r_bottom),
        .rd_data (w_ram_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_top      <= '0;
            r_bottom   <= '0;
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_ae       <= 1'b1;
            r_af       <= 1'b0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
            r_out_zero <= 1'b1;
        end else begin
            if (w_wr_acc) begin
                r_top <= r_top + 1'b1;
            end
            if (w_rd_acc) begin
                r_bottom   <= r_bottom + 1'b1;
                r_out_zero <= 1'b0;
            end
            r_count <= w_count_nxt;
            r_valid <= w_rd_acc;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == c_depth);
            r_ae    <= (w_count_nxt <= c_ae);
            r_af    <= (w_count_nxt >= c_af);
            // A new error in the same cycle as a clear keeps the flag set.
            r_ovf   <= (wt_en & ~w_wr_acc) | (r_ovf & ~err_clr);
            r_unf   <= (rd_en & ~w_rd_acc) | (r_unf & ~err_clr);
        end
    end

    // The RAM output register has no reset, so the post-reset zero is masked here.
    assign buf_out      = r_out_zero ? '0 : w_ram_q;
    assign buf_valid    = r_valid;
    assign buf_empty    = r_empty;
    assign buf_full     = r_full;
    assign almost_empty = r_ae;
    assign almost_full  = r_af;
    assign count        = r_count;
    assign overflow     = r_ovf;
    assign underflow    = r_unf;

endmodule
`default_nettype wire
